// File: rtl/rr_arb2_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2_datapath_pkg
// Purpose  : Shared state encoding and counter width for the 2-way arbiter.
// Revision : 1.0
// ============================================================================
package rr_arb2_datapath_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    function automatic state_t own_state(input logic g);
        return g ? OWN1 : OWN0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2_datapath_mux.sv
`default_nettype none
// ============================================================================
// Module   : MUX2T1_64
// Purpose  : 2:1 data steering mux; sel=0 picks a, sel=1 picks b.
// Revision : 1.0
// ============================================================================
module MUX2T1_64 #(
    parameter int WIDTH = 64
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule
`default_nettype wire

// File: rtl/rr_arb2_datapath.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2_datapath
// Purpose  : Round-robin arbiter sharing one registered datapath between two
//            valid/ready producers, with bounded bursts per owner.
// Revision : 1.0
// ============================================================================
module rr_arb2_datapath
    import rr_arb2_datapath_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_burst = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_prio;
    logic               w_prio_nxt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_src;

    logic               w_gvalid;
    logic               w_g;
    logic               w_load_en;
    logic               w_fire;
    logic [WIDTH-1:0]   w_mux_y;

    // Grant: the owner keeps the path until its burst is spent or it goes
    // quiet; a lone requester is never stalled by the burst limit.
    always_comb begin
        w_gvalid = in0_valid | in1_valid;
        w_g      = 1'b0;
        case (r_state)
            OWN0: begin
                if (in0_valid && (r_cnt < c_burst)) w_g = 1'b0;
                else if (in1_valid)                 w_g = 1'b1;
                else                                w_g = 1'b0;
            end
            OWN1: begin
                if (in1_valid && (r_cnt < c_burst)) w_g = 1'b1;
                else if (in0_valid)                 w_g = 1'b0;
                else                                w_g = in1_valid;
            end
            default: w_g = (in0_valid && in1_valid) ? r_prio : in1_valid;
        endcase
    end

    assign w_load_en = !r_out_valid || out_ready;
    assign w_fire    = w_gvalid && w_load_en && !rst;

    assign sel       = w_gvalid & w_g;
    assign in0_ready = w_fire && !w_g;
    assign in1_ready = w_fire &&  w_g;

    MUX2T1_64 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel (sel),
        .a   (in0_data),
        .b   (in1_data),
        .y   (w_mux_y)
    );

    // A stall (requests pending, output blocked) holds state, cnt and prio.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_prio_nxt  = r_prio;
        if (w_fire) begin
            w_state_nxt = own_state(w_g);
            w_cnt_nxt   = ((r_state == own_state(w_g)) && (r_cnt < c_burst))
                          ? r_cnt + c_one : c_one;
        end else if (!w_gvalid) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            if (r_state == OWN0)      w_prio_nxt = 1'b1;
            else if (r_state == OWN1) w_prio_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_y;
            r_out_src   <= w_g;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign busy      = (r_state != IDLE) || r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb2_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb2_datapath
// Purpose  : Self-checking bench for rr_arb2_datapath against a rule model.
// Revision : 1.0
// ============================================================================
module tb_rr_arb2_datapath;

    localparam int WIDTH = 64;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             v0, v1, ordy;
    logic [WIDTH-1:0] d0, d1;
    logic             r0, r1, ov, os, sel, busy;
    logic [WIDTH-1:0] od;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rr_arb2_datapath #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(v0), .in0_data(d0), .in0_ready(r0),
        .in1_valid(v1), .in1_data(d1), .in1_ready(r1),
        .out_valid(ov), .out_data(od), .out_src(os), .out_ready(ordy),
        .sel(sel), .busy(busy)
    );

    // Reference model: who owns the path, how long it has held it, who is
    // favoured on a tie from idle, and the single output slot.
    int               m_owner;
    int               m_run;
    bit               m_prio;
    bit               m_ov;
    logic [WIDTH-1:0] m_od;
    bit               m_os;
    int               exp_g;
    bit               exp_load, exp_r0, exp_r1, exp_sel;

    function automatic int grant_of(bit a0, bit a1);
        bit mine;
        bit other;
        if (!a0 && !a1) return -1;
        if (m_owner < 0) return (a0 && a1) ? int'(m_prio) : (a1 ? 1 : 0);
        mine  = (m_owner == 0) ? a0 : a1;
        other = (m_owner == 0) ? a1 : a0;
        if (mine && m_run < BURST) return m_owner;
        if (other) return 1 - m_owner;
        return m_owner;
    endfunction

    task automatic compute();
        exp_g    = grant_of(v0, v1);
        exp_load = !m_ov || ordy;
        exp_r0   = !rst && exp_load && exp_g == 0;
        exp_r1   = !rst && exp_load && exp_g == 1;
        exp_sel  = (exp_g == 1);
    endtask

    task automatic step();
        if (rst) begin
            m_owner = -1; m_run = 0; m_prio = 0;
            m_ov = 0; m_od = '0; m_os = 0;
        end else if (exp_g >= 0 && exp_load) begin
            m_od    = (exp_g == 1) ? d1 : d0;
            m_os    = (exp_g == 1);
            m_ov    = 1;
            m_run   = (m_owner == exp_g && m_run < BURST) ? m_run + 1 : 1;
            m_owner = exp_g;
        end else begin
            if (ordy) m_ov = 0;
            if (exp_g < 0) begin
                if (m_owner >= 0) m_prio = (m_owner == 0);
                m_owner = -1;
                m_run   = 0;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1; v0 = 0; v1 = 0; ordy = 0; d0 = '0; d1 = '0;
        @(negedge clk); compute(); step();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; v0 = 1; v1 = 1; ordy = 1;
        d0 = 64'hAAAA_0000_0000_0001; d1 = 64'hBBBB_0000_0000_0002;
        @(negedge clk); compute();
        n_checks++;
        if (r0 !== 1'b0 || r1 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready: got r0=%b r1=%b, need 0 0", r0, r1);
        end
        step();
        @(posedge clk); #1;
        rst = 0; v0 = 0; v1 = 0;
        @(negedge clk); compute();
        n_checks++;
        if (ov !== 1'b0 || od !== '0 || os !== 1'b0 || busy !== 1'b0 || sel !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got ov=%b od=%h os=%b busy=%b sel=%b, need all 0",
                     ov, od, os, busy, sel);
        end
        step();
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        apply_reset();
        v0 = 1; d0 = 64'h0123_4567_89AB_CDEF; ordy = 1;
        @(negedge clk); compute();
        n_checks++;
        if (r0 !== 1'b1 || r1 !== 1'b0 || sel !== 1'b0) begin
            n_errors++;
            $display("FAIL single_accept: got r0=%b r1=%b sel=%b, need 1 0 0", r0, r1, sel);
        end
        step();
        @(posedge clk); #1;
        v0 = 0;
        @(negedge clk); compute();
        n_checks++;
        if (ov !== 1'b1 || od !== 64'h0123_4567_89AB_CDEF || os !== 1'b0) begin
            n_errors++;
            $display("FAIL single_out: got ov=%b od=%h os=%b, need 1 0123456789abcdef 0",
                     ov, od, os);
        end
        step();
        @(posedge clk); #1;
    endtask

    task automatic test_fair();
        int bad = 0;
        apply_reset();
        v0 = 1; v1 = 1; ordy = 1;
        for (int i = 0; i < 17; i++) begin
            d0 = {32'h0, 32'(i)}; d1 = {32'hFFFF_FFFF, 32'(i)};
            @(negedge clk); compute();
            if (i > 0 && (ov !== 1'b1 || os !== 1'(((i - 1) / BURST) % 2))) bad++;
            step();
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL fair_sequence: got %0d wrong out_src/out_valid cycles, need 0", bad);
        end
        v0 = 0; v1 = 0;
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held;
        int               bad = 0;
        apply_reset();
        v0 = 1; v1 = 1; ordy = 1; d0 = 64'h1111_2222_3333_4444; d1 = 64'h5555_6666_7777_8888;
        @(negedge clk); compute(); step();
        @(posedge clk); #1;
        held = 64'h1111_2222_3333_4444;
        ordy = 0; d0 = 64'hDEAD_BEEF_0000_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); compute();
            if (r0 !== 1'b0 || r1 !== 1'b0 || ov !== 1'b1 || od !== held) bad++;
            step();
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL backpressure_hold: got %0d bad stall cycles, need 0", bad);
        end
        ordy = 1;
        @(negedge clk); compute();
        n_checks++;
        if (r0 !== exp_r0 || r1 !== exp_r1 || r0 !== 1'b1) begin
            n_errors++;
            $display("FAIL backpressure_release: got r0=%b r1=%b, need %b %b", r0, r1, exp_r0, exp_r1);
        end
        step();
        @(posedge clk); #1;
        @(negedge clk); compute();
        n_checks++;
        if (ov !== 1'b1 || od !== 64'hDEAD_BEEF_0000_0000 || os !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure_next: got ov=%b od=%h os=%b, need 1 deadbeef00000000 0", ov, od, os);
        end
        step();
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
    endtask

    task automatic test_lone();
        int xfers = 0;
        int bad   = 0;
        apply_reset();
        v1 = 1; ordy = 1;
        for (int i = 0; i < 11; i++) begin
            if (i == 10) v1 = 0;
            @(negedge clk); compute();
            if (r1 === 1'b1) xfers++;
            if (i > 0 && (ov !== 1'b1 || os !== 1'b1 || od !== m_od)) bad++;
            step();
            @(posedge clk); #1;
            d1 = {$urandom, $urandom};
        end
        n_checks++;
        if (xfers != 10 || bad != 0) begin
            n_errors++;
            $display("FAIL lone_requester: got %0d transfers %0d bad outputs, need 10 and 0", xfers, bad);
        end
    endtask

    task automatic test_mid_drop();
        apply_reset();
        v0 = 1; v1 = 1; ordy = 1; d1 = 64'hCAFE_F00D_1234_5678;
        for (int i = 0; i < 2; i++) begin
            d0 = {32'h0, 32'(i)};
            @(negedge clk); compute(); step();
            @(posedge clk); #1;
        end
        v0 = 0;
        @(negedge clk); compute();
        n_checks++;
        if (r1 !== 1'b1 || r0 !== 1'b0 || sel !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_drop_grant: got r0=%b r1=%b sel=%b, need 0 1 1", r0, r1, sel);
        end
        step();
        @(posedge clk); #1;
        v1 = 0;
        @(negedge clk); compute();
        n_checks++;
        if (ov !== 1'b1 || os !== 1'b1 || od !== 64'hCAFE_F00D_1234_5678) begin
            n_errors++;
            $display("FAIL mid_drop_out: got ov=%b os=%b od=%h, need 1 1 cafef00d12345678", ov, os, od);
        end
        step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        v0 = 1; v1 = 1; ordy = 1;
        for (int i = 0; i < 6; i++) begin
            d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
            @(negedge clk); compute(); step();
            @(posedge clk); #1;
        end
        rst = 1; ordy = 0;
        @(negedge clk); compute();
        n_checks++;
        if (r0 !== 1'b0 || r1 !== 1'b0 || ov !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_ready: got r0=%b r1=%b ov=%b, need 0 0 1", r0, r1, ov);
        end
        step();
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk); compute();
        n_checks++;
        if (ov !== 1'b0 || busy !== 1'b0 || r0 !== 1'b1 || r1 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_after: got ov=%b busy=%b r0=%b r1=%b, need 0 0 1 0", ov, busy, r0, r1);
        end
        step();
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
    endtask

    task automatic test_random();
        int bad_in  = 0;
        int bad_out = 0;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            // Producers keep valid and data stable until they are accepted.
            if (!(v0 && !exp_r0) || i == 0) begin
                v0 = ($urandom_range(0, 3) != 0); d0 = {$urandom, $urandom};
            end
            if (!(v1 && !exp_r1) || i == 0) begin
                v1 = ($urandom_range(0, 3) != 0); d1 = {$urandom, $urandom};
            end
            ordy = ($urandom_range(0, 2) != 0);
            @(negedge clk); compute();
            if (r0 !== exp_r0 || r1 !== exp_r1 || (exp_g >= 0 && sel !== exp_sel)) bad_in++;
            if (ov !== m_ov || busy !== (m_owner >= 0 || m_ov) ||
                (m_ov && (od !== m_od || os !== m_os))) bad_out++;
            step();
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad_in != 0) begin
            n_errors++;
            $display("FAIL random_grant: got %0d cycles with wrong ready/sel, need 0", bad_in);
        end
        n_checks++;
        if (bad_out != 0) begin
            n_errors++;
            $display("FAIL random_output: got %0d cycles with wrong output/busy, need 0", bad_out);
        end
        v0 = 0; v1 = 0;
    endtask

    initial begin
        rst = 1; v0 = 0; v1 = 0; ordy = 0; d0 = '0; d1 = '0;
        m_owner = -1; m_run = 0; m_prio = 0; m_ov = 0; m_od = '0; m_os = 0;
        exp_r0 = 0; exp_r1 = 0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_fair();
        test_backpressure();
        test_lone();
        test_mid_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
